// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared widths, CSR addresses, trap cause codes, the encoded
//               trap request type and the mtvec target helper used by the
//               machine-mode trap sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package trap_ctrl_pkg;

    localparam int REG_BUS      = 32;
    localparam int CSR_ADDR_BUS = 12;

    // CSR addresses reached through the trap-side channel
    localparam logic [CSR_ADDR_BUS-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_ADDR_BUS-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_ADDR_BUS-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_ADDR_BUS-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_ADDR_BUS-1:0] CSR_MTVAL   = 12'h343;

    // mcause values; bit 31 marks an interrupt
    localparam logic [REG_BUS-1:0] TRAP_CAUSE_ILLEGAL = 32'h0000_0002;
    localparam logic [REG_BUS-1:0] TRAP_CAUSE_EBREAK  = 32'h0000_0003;
    localparam logic [REG_BUS-1:0] TRAP_CAUSE_ECALL   = 32'h0000_000B;
    localparam logic [REG_BUS-1:0] TRAP_CAUSE_EXT     = 32'h8000_000B;
    localparam logic [REG_BUS-1:0] TRAP_CAUSE_SOFT    = 32'h8000_0003;
    localparam logic [REG_BUS-1:0] TRAP_CAUSE_TIMER   = 32'h8000_0007;

    // Result of cause arbitration for the instruction in execute
    typedef struct packed {
        logic               take;
        logic               is_mret;
        logic               is_irq;
        logic [REG_BUS-1:0] cause;
        logic [REG_BUS-1:0] tval;
    } trap_req_t;

    // Handler address from mtvec. Vectored mode (mode = 01) only offsets
    // interrupts; synchronous exceptions always land on the base.
    function automatic logic [REG_BUS-1:0] mtvec_target(
        input logic [REG_BUS-1:0] mtvec,
        input logic [4:0]         code,
        input logic               is_irq
    );
        logic [REG_BUS-1:0] base;
        base = {mtvec[31:2], 2'b00};
        if (is_irq && (mtvec[1:0] == 2'b01)) begin
            return base + {25'd0, code, 2'b00};
        end
        return base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_if
// Description : Trap-side CSR access channel between the trap sequencer
//               (master) and the CSR register file (slave).
//   trap_csr_we_o     master->slave  write enable
//   trap_csr_addr_o   master->slave  CSR address
//   trap_csr_wdata_o  master->slave  write data
//   trap_csr_rdata_i  slave->master  read data, combinational from address
// Revision    : 1.0  initial release
// ============================================================================
interface trap_ctrl_if;
    import trap_ctrl_pkg::*;

    logic                    trap_csr_we_o;
    logic [CSR_ADDR_BUS-1:0] trap_csr_addr_o;
    logic [REG_BUS-1:0]      trap_csr_wdata_o;
    logic [REG_BUS-1:0]      trap_csr_rdata_i;

    modport master (
        output trap_csr_we_o,
        output trap_csr_addr_o,
        output trap_csr_wdata_o,
        input  trap_csr_rdata_i
    );

    modport slave (
        input  trap_csr_we_o,
        input  trap_csr_addr_o,
        input  trap_csr_wdata_o,
        output trap_csr_rdata_i
    );

endinterface
`default_nettype wire

// File: rtl/trap_cause_enc.sv
`default_nettype none
// ============================================================================
// Module      : trap_cause_enc
// Description : Combinational priority encoder for trap events.
//               illegal > ebreak > ecall > mret > interrupts; interrupts only
//               when the global enable is set, external > software > timer.
//   inst_valid_i          instruction at commit boundary
//   inst_pc_i / inst_i    PC and word of that instruction
//   *_i flags             decoder flags and masked interrupt requests
//   mie_i                 mstatus.MIE
//   req_o                 {take, is_mret, is_irq, cause, tval}
// Revision    : 1.0  initial release
// ============================================================================
module trap_cause_enc
    import trap_ctrl_pkg::*;
(
    input  wire logic               inst_valid_i,
    input  wire logic [REG_BUS-1:0] inst_pc_i,
    input  wire logic [REG_BUS-1:0] inst_i,
    input  wire logic               illegal_i,
    input  wire logic               ebreak_i,
    input  wire logic               ecall_i,
    input  wire logic               mret_i,
    input  wire logic               ex_trap_valid_i,
    input  wire logic               tcmp_trap_valid_i,
    input  wire logic               soft_trap_valid_i,
    input  wire logic               mie_i,
    output trap_req_t               req_o
);

    always_comb begin
        req_o = '0;
        if (inst_valid_i) begin
            if (illegal_i) begin
                req_o.take  = 1'b1;
                req_o.cause = TRAP_CAUSE_ILLEGAL;
                req_o.tval  = inst_i;
            end else if (ebreak_i) begin
                req_o.take  = 1'b1;
                req_o.cause = TRAP_CAUSE_EBREAK;
                req_o.tval  = inst_pc_i;
            end else if (ecall_i) begin
                req_o.take  = 1'b1;
                req_o.cause = TRAP_CAUSE_ECALL;
            end else if (mret_i) begin
                req_o.take    = 1'b1;
                req_o.is_mret = 1'b1;
            end else if (mie_i) begin
                if (ex_trap_valid_i) begin
                    req_o.take   = 1'b1;
                    req_o.is_irq = 1'b1;
                    req_o.cause  = TRAP_CAUSE_EXT;
                end else if (soft_trap_valid_i) begin
                    req_o.take   = 1'b1;
                    req_o.is_irq = 1'b1;
                    req_o.cause  = TRAP_CAUSE_SOFT;
                end else if (tcmp_trap_valid_i) begin
                    req_o.take   = 1'b1;
                    req_o.is_irq = 1'b1;
                    req_o.cause  = TRAP_CAUSE_TIMER;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer. Accepts one trap/interrupt/mret
//               per idle cycle, stalls the pipeline, updates mepc, mcause,
//               mtval and mstatus one CSR access per cycle and redirects
//               fetch to the handler or the return address.
//   clk, rst_n                 clock, async active-low reset
//   inst_valid_i/pc/inst       instruction in execute
//   illegal/ebreak/ecall/mret  decoder flags
//   ex/tcmp/soft_trap_valid_i  masked interrupt requests
//   mstatus_MIE3_i, mepc_i     direct CSR values
//   trap_csr                   CSR access channel (master)
//   busy_o, jump_o, jump_addr_o  stall, redirect strobe, redirect target
// Revision    : 1.0  initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               inst_valid_i,
    input  wire logic [REG_BUS-1:0] inst_pc_i,
    input  wire logic [REG_BUS-1:0] inst_i,
    input  wire logic               illegal_i,
    input  wire logic               ebreak_i,
    input  wire logic               ecall_i,
    input  wire logic               mret_i,
    input  wire logic               ex_trap_valid_i,
    input  wire logic               tcmp_trap_valid_i,
    input  wire logic               soft_trap_valid_i,
    input  wire logic               mstatus_MIE3_i,
    input  wire logic [REG_BUS-1:0] mepc_i,
    trap_ctrl_if.master             trap_csr,
    output logic                    busy_o,
    output logic                    jump_o,
    output logic [REG_BUS-1:0]      jump_addr_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_MEPC    = 4'd1,
        S_MCAUSE  = 4'd2,
        S_MTVAL   = 4'd3,
        S_MSTATUS = 4'd4,
        S_TJUMP   = 4'd5,
        S_RSTATUS = 4'd6,
        S_RJUMP   = 4'd7
    } state_t;

    state_t                  r_state;
    logic [REG_BUS-1:0]      r_cause;
    logic [REG_BUS-1:0]      r_epc;
    logic [REG_BUS-1:0]      r_tval;
    logic                    r_is_irq;
    logic                    r_we;
    logic [CSR_ADDR_BUS-1:0] r_addr;
    logic                    r_jump;
    trap_req_t               w_req;
    logic [REG_BUS-1:0]      w_rdata;

    trap_cause_enc u_cause_enc (
        .inst_valid_i      (inst_valid_i),
        .inst_pc_i         (inst_pc_i),
        .inst_i            (inst_i),
        .illegal_i         (illegal_i),
        .ebreak_i          (ebreak_i),
        .ecall_i           (ecall_i),
        .mret_i            (mret_i),
        .ex_trap_valid_i   (ex_trap_valid_i),
        .tcmp_trap_valid_i (tcmp_trap_valid_i),
        .soft_trap_valid_i (soft_trap_valid_i),
        .mie_i             (mstatus_MIE3_i),
        .req_o             (w_req)
    );

    assign w_rdata = trap_csr.trap_csr_rdata_i;

    // Sequencer plus event latches. we/addr/jump are registered alongside
    // the state so they are valid from the start of each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cause  <= '0;
            r_epc    <= '0;
            r_tval   <= '0;
            r_is_irq <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_jump   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req.take) begin
                        r_cause  <= w_req.cause;
                        r_epc    <= inst_pc_i;
                        r_tval   <= w_req.tval;
                        r_is_irq <= w_req.is_irq;
                        r_we     <= 1'b1;
                        if (w_req.is_mret) begin
                            r_state <= S_RSTATUS;
                            r_addr  <= CSR_MSTATUS;
                        end else begin
                            r_state <= S_MEPC;
                            r_addr  <= CSR_MEPC;
                        end
                    end
                end
                S_MEPC: begin
                    r_state <= S_MCAUSE;
                    r_addr  <= CSR_MCAUSE;
                end
                S_MCAUSE: begin
                    r_state <= S_MTVAL;
                    r_addr  <= CSR_MTVAL;
                end
                S_MTVAL: begin
                    r_state <= S_MSTATUS;
                    r_addr  <= CSR_MSTATUS;
                end
                S_MSTATUS: begin
                    // mtvec is only read, so the write strobe drops here
                    r_state <= S_TJUMP;
                    r_we    <= 1'b0;
                    r_addr  <= CSR_MTVEC;
                    r_jump  <= 1'b1;
                end
                S_RSTATUS: begin
                    r_state <= S_RJUMP;
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                    r_jump  <= 1'b1;
                end
                S_TJUMP, S_RJUMP: begin
                    r_state <= S_IDLE;
                    r_addr  <= '0;
                    r_jump  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                    r_jump  <= 1'b0;
                end
            endcase
        end
    end

    // Write data is combinational because the mstatus updates are
    // read-modify-write of the value returned in the same cycle.
    always_comb begin
        trap_csr.trap_csr_wdata_o = '0;
        case (r_state)
            S_MEPC:    trap_csr.trap_csr_wdata_o = r_epc;
            S_MCAUSE:  trap_csr.trap_csr_wdata_o = r_cause;
            S_MTVAL:   trap_csr.trap_csr_wdata_o = r_tval;
            // MPIE <- MIE, MIE <- 0
            S_MSTATUS: trap_csr.trap_csr_wdata_o =
                           {w_rdata[31:8], w_rdata[3], w_rdata[6:4], 1'b0, w_rdata[2:0]};
            // MIE <- MPIE, MPIE <- 1
            S_RSTATUS: trap_csr.trap_csr_wdata_o =
                           {w_rdata[31:8], 1'b1, w_rdata[6:4], w_rdata[7], w_rdata[2:0]};
            default:   trap_csr.trap_csr_wdata_o = '0;
        endcase
    end

    always_comb begin
        jump_addr_o = RESET_PC;
        case (r_state)
            S_TJUMP: jump_addr_o = mtvec_target(w_rdata, r_cause[4:0], r_is_irq);
            S_RJUMP: jump_addr_o = mepc_i;
            default: jump_addr_o = RESET_PC;
        endcase
    end

    assign trap_csr.trap_csr_we_o   = r_we;
    assign trap_csr.trap_csr_addr_o = r_addr;
    assign jump_o                   = r_jump;
    // Combinational so the pipeline is held in the acceptance cycle itself
    assign busy_o                   = (r_state != S_IDLE) | w_req.take;

endmodule
`default_nettype wire
